// File: rtl/qs_gen.sv
// Queue selector: routes IBM metadata to TSN slot, RC/PTP or BE queues, frees errored/dropped pointers.
// Define QS_DROP_EN to honour in_qs_q_full (drop + free-back + drop_cnt); otherwise full flags are ignored.
module qs_gen #(
    parameter int PTR_W  = 9,
    parameter int TS_NUM = 2,
    parameter int CRD_W  = 7,
    localparam int TS_W  = $clog2(TS_NUM),
    localparam int MD_W  = PTR_W + 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [TS_W-1:0]           in_qs_time_slot,
    input  logic [MD_W-1:0]           in_qs_md,
    input  logic                      in_qs_md_wr,
    input  logic [TS_NUM+1:0]         in_qs_q_full,
    output logic [TS_NUM*PTR_W-1:0]   out_qs_ts_md,
    output logic [TS_NUM-1:0]         out_qs_ts_md_wr,
    output logic [CRD_W+PTR_W-1:0]    out_qs_rc_md,
    output logic                      out_qs_rc_md_wr,
    output logic [PTR_W-1:0]          out_qs_be_md,
    output logic                      out_qs_be_md_wr,
    output logic [PTR_W-1:0]          out_qs_free_ptr,
    output logic                      out_qs_free_wr,
    input  logic                      in_qs_cnt_clr,
    output logic [15:0]               out_qs_drop_cnt,
    output logic [15:0]               out_qs_err_cnt
);

    localparam logic [31:0] CRD_MAX = (32'd1 << CRD_W) - 32'd1;

    logic [2:0]       typ;
    logic [11:0]      len;
    logic [PTR_W-1:0] ptr;
    logic [31:0]      beats;
    logic [CRD_W-1:0] crd;
    logic [CRD_W-1:0] rc_crd;
    logic [TS_NUM-1:0] ts_full;
    logic slot_ok;
    logic is_ts, is_rc, is_be, is_err, tgt_full;
    logic drop_ev, err_ev;

    assign typ     = in_qs_md[MD_W-1 -: 3];
    assign len     = in_qs_md[PTR_W +: 12];
    assign ptr     = in_qs_md[PTR_W-1:0];
    assign beats   = {24'd0, len[11:4]};
    assign ts_full = in_qs_q_full[TS_NUM-1:0];
    assign slot_ok = {{(32-TS_W){1'b0}}, in_qs_time_slot} < 32'(TS_NUM);

    // Credit is beats minus two, clamped at both ends of the field range
    always_comb begin
        if (beats < 32'd2)
            crd = '0;
        else if (beats - 32'd2 > CRD_MAX)
            crd = CRD_MAX[CRD_W-1:0];
        else
            crd = CRD_W'(beats - 32'd2);
    end

    always_comb begin
        is_ts  = 1'b0;
        is_rc  = 1'b0;
        is_be  = 1'b0;
        is_err = 1'b0;
        rc_crd = '0;
        case (typ)
            3'd3: begin
                if (slot_ok) is_ts = 1'b1;
                else         is_err = 1'b1;
            end
            3'd1: begin
                is_rc  = 1'b1;
                rc_crd = crd;
            end
            3'd2:    is_rc  = 1'b1;
            3'd0:    is_be  = 1'b1;
            default: is_err = 1'b1;
        endcase
    end

`ifdef QS_DROP_EN
    always_comb begin
        tgt_full = 1'b0;
        if (is_ts)      tgt_full = ts_full[in_qs_time_slot];
        else if (is_rc) tgt_full = in_qs_q_full[TS_NUM];
        else if (is_be) tgt_full = in_qs_q_full[TS_NUM+1];
    end
`else
    logic unused_full;
    assign unused_full = ^ts_full ^ in_qs_q_full[TS_NUM] ^ in_qs_q_full[TS_NUM+1];
    assign tgt_full    = 1'b0;
`endif

    assign drop_ev = in_qs_md_wr & ~is_err & tgt_full;
    assign err_ev  = in_qs_md_wr & is_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_qs_ts_md    <= '0;
            out_qs_ts_md_wr <= '0;
            out_qs_rc_md    <= '0;
            out_qs_rc_md_wr <= 1'b0;
            out_qs_be_md    <= '0;
            out_qs_be_md_wr <= 1'b0;
            out_qs_free_ptr <= '0;
            out_qs_free_wr  <= 1'b0;
            out_qs_err_cnt  <= '0;
        end else begin
            out_qs_ts_md    <= '0;
            out_qs_ts_md_wr <= '0;
            out_qs_rc_md    <= '0;
            out_qs_rc_md_wr <= 1'b0;
            out_qs_be_md    <= '0;
            out_qs_be_md_wr <= 1'b0;
            out_qs_free_ptr <= '0;
            out_qs_free_wr  <= 1'b0;
            if (in_qs_md_wr) begin
                if (is_err || tgt_full) begin
                    out_qs_free_ptr <= ptr;
                    out_qs_free_wr  <= 1'b1;
                end else if (is_ts) begin
                    for (int k = 0; k < TS_NUM; k++) begin
                        if (in_qs_time_slot == TS_W'(k)) begin
                            out_qs_ts_md[k*PTR_W +: PTR_W] <= ptr;
                            out_qs_ts_md_wr[k]             <= 1'b1;
                        end
                    end
                end else if (is_rc) begin
                    out_qs_rc_md    <= {rc_crd, ptr};
                    out_qs_rc_md_wr <= 1'b1;
                end else begin
                    out_qs_be_md    <= ptr;
                    out_qs_be_md_wr <= 1'b1;
                end
            end
            if (in_qs_cnt_clr)
                out_qs_err_cnt <= {15'd0, err_ev};
            else if (err_ev && out_qs_err_cnt != 16'hFFFF)
                out_qs_err_cnt <= out_qs_err_cnt + 16'd1;
        end
    end

`ifdef QS_DROP_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            out_qs_drop_cnt <= '0;
        else if (in_qs_cnt_clr)
            out_qs_drop_cnt <= {15'd0, drop_ev};
        else if (drop_ev && out_qs_drop_cnt != 16'hFFFF)
            out_qs_drop_cnt <= out_qs_drop_cnt + 16'd1;
    end
`else
    assign out_qs_drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_qs_gen.sv
// Scoreboard bench for qs_gen (TS_NUM=3 so an out-of-range slot is reachable).
// Drop-path vectors switch on QS_DROP_EN.
module tb_qs_gen;

    localparam int PTR_W  = 9;
    localparam int TS_NUM = 3;
    localparam int CRD_W  = 7;

    typedef enum int {K_NONE, K_TS, K_RC, K_BE, K_DROP, K_ERR} kind_t;

    typedef struct {
        int          due;
        string       nm;
        logic [98:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  slot = '0;
    logic [23:0] md = '0;
    logic        md_wr = 1'b0;
    logic [4:0]  full = '0;
    logic        clr = 1'b0;
    logic [26:0] ts_md;
    logic [2:0]  ts_wr;
    logic [15:0] rc_md;
    logic        rc_wr;
    logic [8:0]  be_md;
    logic        be_wr;
    logic [8:0]  free_ptr;
    logic        free_wr;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   started = 1'b0;
    logic [15:0] c_err = '0;
    logic [15:0] c_drop = '0;

    qs_gen #(.PTR_W(PTR_W), .TS_NUM(TS_NUM), .CRD_W(CRD_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_qs_time_slot(slot),
        .in_qs_md(md),
        .in_qs_md_wr(md_wr),
        .in_qs_q_full(full),
        .out_qs_ts_md(ts_md),
        .out_qs_ts_md_wr(ts_wr),
        .out_qs_rc_md(rc_md),
        .out_qs_rc_md_wr(rc_wr),
        .out_qs_be_md(be_md),
        .out_qs_be_md_wr(be_wr),
        .out_qs_free_ptr(free_ptr),
        .out_qs_free_wr(free_wr),
        .in_qs_cnt_clr(clr),
        .out_qs_drop_cnt(drop_cnt),
        .out_qs_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus; the expected response is hand-specified by kind and credit.
    task automatic drive(input logic r, input logic w, input logic [2:0] t,
                         input logic [11:0] ln, input logic [8:0] p,
                         input logic [1:0] s, input logic [4:0] f, input logic c,
                         input kind_t k, input logic [6:0] crd, input string nm);
        exp_t e;
        logic [26:0] e_ts_md;
        logic [2:0]  e_ts_wr;
        logic [15:0] e_rc_md;
        logic        e_rc_wr;
        logic [8:0]  e_be_md;
        logic        e_be_wr;
        logic [8:0]  e_fp;
        logic        e_fw;
        int          sh;
        @(negedge clk);
        rst_n = r;
        md_wr = w;
        md    = {t, ln, p};
        slot  = s;
        full  = f;
        clr   = c;
        e_ts_md = '0; e_ts_wr = '0; e_rc_md = '0; e_rc_wr = 1'b0;
        e_be_md = '0; e_be_wr = 1'b0; e_fp = '0; e_fw = 1'b0;
        sh = int'(s) * PTR_W;
        case (k)
            K_TS: begin
                e_ts_wr = 3'b001 << s;
                e_ts_md = {18'd0, p} << sh;
            end
            K_RC: begin
                e_rc_md = {crd, p};
                e_rc_wr = 1'b1;
            end
            K_BE: begin
                e_be_md = p;
                e_be_wr = 1'b1;
            end
            K_DROP, K_ERR: begin
                e_fp = p;
                e_fw = 1'b1;
            end
            default: ;
        endcase
        if (!r) begin
            c_err  = '0;
            c_drop = '0;
        end else if (c) begin
            c_err  = (k == K_ERR)  ? 16'd1 : 16'd0;
            c_drop = (k == K_DROP) ? 16'd1 : 16'd0;
        end else begin
            if (k == K_ERR && c_err != 16'hFFFF)   c_err++;
            if (k == K_DROP && c_drop != 16'hFFFF) c_drop++;
        end
        e.due = cyc + 1;
        e.nm  = nm;
        e.v   = {e_ts_md, e_ts_wr, e_rc_md, e_rc_wr, e_be_md, e_be_wr,
                 e_fp, e_fw, c_drop, c_err};
        sbq.push_back(e);
        started = 1'b1;
    endtask

    task automatic idle(input string nm);
        drive(1'b1, 1'b0, 3'd0, 12'd0, 9'd0, 2'd0, 5'd0, 1'b0, K_NONE, 7'd0, nm);
    endtask

    // Monitor: every cycle, compare the full output tuple against the entry due now.
    initial begin
        exp_t e;
        logic [98:0] act;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            act = {ts_md, ts_wr, rc_md, rc_wr, be_md, be_wr,
                   free_ptr, free_wr, drop_cnt, err_cnt};
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                n_tests++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
                end
            end else if (started && (ts_wr != 0 || rc_wr || be_wr || free_wr)) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got %h expected no strobe", act);
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 3'd0, 12'd0, 9'd0, 2'd0, 5'd0, 1'b0, K_NONE, 7'd0, "reset");
        drive(1'b0, 1'b1, 3'd3, 12'd64, 9'h0AA, 2'd0, 5'd0, 1'b0, K_NONE, 7'd0, "reset_wr");
        idle("idle0");

        drive(1'b1, 1'b1, 3'd3, 12'd64, 9'h005, 2'd0, 5'd0, 1'b0, K_TS, 7'd0, "ts_slot0");
        drive(1'b1, 1'b1, 3'd3, 12'd64, 9'h005, 2'd1, 5'd0, 1'b0, K_TS, 7'd0, "ts_slot1");
        drive(1'b1, 1'b1, 3'd3, 12'd80, 9'h1C3, 2'd2, 5'd0, 1'b0, K_TS, 7'd0, "ts_slot2");
        idle("idle1");

        drive(1'b1, 1'b1, 3'd1, 12'd1500, 9'h01A, 2'd0, 5'd0, 1'b0, K_RC, 7'd91, "rc_1500");
        drive(1'b1, 1'b1, 3'd1, 12'd16, 9'h01B, 2'd1, 5'd0, 1'b0, K_RC, 7'd0, "rc_16");
        drive(1'b1, 1'b1, 3'd1, 12'd4095, 9'h01C, 2'd0, 5'd0, 1'b0, K_RC, 7'd127, "rc_4095");
        drive(1'b1, 1'b1, 3'd1, 12'd32, 9'h01D, 2'd0, 5'd0, 1'b0, K_RC, 7'd0, "rc_32");
        drive(1'b1, 1'b1, 3'd1, 12'd48, 9'h01E, 2'd0, 5'd0, 1'b0, K_RC, 7'd1, "rc_48");
        drive(1'b1, 1'b1, 3'd1, 12'd2063, 9'h01F, 2'd0, 5'd0, 1'b0, K_RC, 7'd126, "rc_2063");
        drive(1'b1, 1'b1, 3'd2, 12'd1500, 9'h020, 2'd0, 5'd0, 1'b0, K_RC, 7'd0, "ptp");
        drive(1'b1, 1'b1, 3'd0, 12'd100, 9'h1FF, 2'd2, 5'd0, 1'b0, K_BE, 7'd0, "be");
        drive(1'b1, 1'b1, 3'd0, 12'd100, 9'h0F0, 2'd0, 5'b01111, 1'b0, K_BE, 7'd0, "be_other_full");

`ifdef QS_DROP_EN
        drive(1'b1, 1'b1, 3'd0, 12'd100, 9'h033, 2'd0, 5'b10000, 1'b0, K_DROP, 7'd0, "be_full");
        drive(1'b1, 1'b1, 3'd3, 12'd100, 9'h034, 2'd1, 5'b00010, 1'b0, K_DROP, 7'd0, "ts1_full");
        drive(1'b1, 1'b1, 3'd2, 12'd100, 9'h035, 2'd0, 5'b01000, 1'b0, K_DROP, 7'd0, "rc_full");
`else
        drive(1'b1, 1'b1, 3'd0, 12'd100, 9'h033, 2'd0, 5'b10000, 1'b0, K_BE, 7'd0, "be_full_ign");
        drive(1'b1, 1'b1, 3'd3, 12'd100, 9'h034, 2'd1, 5'b00010, 1'b0, K_TS, 7'd0, "ts1_full_ign");
        drive(1'b1, 1'b1, 3'd2, 12'd100, 9'h035, 2'd0, 5'b01000, 1'b0, K_RC, 7'd0, "rc_full_ign");
`endif

        drive(1'b1, 1'b1, 3'd5, 12'd100, 9'h040, 2'd0, 5'd0, 1'b0, K_ERR, 7'd0, "err_type5");
        drive(1'b1, 1'b1, 3'd3, 12'd100, 9'h041, 2'd3, 5'd0, 1'b0, K_ERR, 7'd0, "err_slot3");
        drive(1'b1, 1'b1, 3'd7, 12'd100, 9'h042, 2'd0, 5'b11111, 1'b0, K_ERR, 7'd0, "err_type7_full");
        drive(1'b1, 1'b1, 3'd4, 12'd100, 9'h043, 2'd0, 5'd0, 1'b0, K_ERR, 7'd0, "err_type4");
        drive(1'b1, 1'b1, 3'd6, 12'd100, 9'h044, 2'd0, 5'd0, 1'b0, K_ERR, 7'd0, "err_type6");
        drive(1'b1, 1'b1, 3'd6, 12'd100, 9'h045, 2'd0, 5'd0, 1'b1, K_ERR, 7'd0, "clr_with_err");
        drive(1'b1, 1'b0, 3'd0, 12'd0, 9'd0, 2'd0, 5'd0, 1'b1, K_NONE, 7'd0, "clr_idle");

`ifdef QS_DROP_EN
        for (int i = 0; i < 70000; i++)
            drive(1'b1, 1'b1, 3'd0, 12'd64, 9'(i), 2'd0, 5'b10000, 1'b0, K_DROP, 7'd0, "drop_sat");
        drive(1'b1, 1'b1, 3'd0, 12'd64, 9'h066, 2'd0, 5'b10000, 1'b1, K_DROP, 7'd0, "clr_with_drop");
`else
        for (int i = 0; i < 70000; i++)
            drive(1'b1, 1'b1, 3'd6, 12'd64, 9'(i), 2'd0, 5'd0, 1'b0, K_ERR, 7'd0, "err_sat");
`endif
        idle("idle_sat");

        drive(1'b1, 1'b1, 3'd3, 12'd64, 9'h071, 2'd1, 5'd0, 1'b0, K_TS, 7'd0, "stream_ts");
        drive(1'b1, 1'b1, 3'd1, 12'd1500, 9'h072, 2'd0, 5'd0, 1'b0, K_RC, 7'd91, "stream_rc");
        drive(1'b1, 1'b1, 3'd5, 12'd64, 9'h073, 2'd0, 5'd0, 1'b0, K_ERR, 7'd0, "stream_err");
        drive(1'b0, 1'b1, 3'd0, 12'd64, 9'h074, 2'd0, 5'd0, 1'b0, K_NONE, 7'd0, "rst_mid_be");
        drive(1'b0, 1'b1, 3'd7, 12'd64, 9'h075, 2'd0, 5'd0, 1'b0, K_NONE, 7'd0, "rst_mid_err");
        drive(1'b1, 1'b1, 3'd3, 12'd64, 9'h076, 2'd2, 5'd0, 1'b0, K_TS, 7'd0, "resume_ts");
        drive(1'b1, 1'b1, 3'd4, 12'd64, 9'h077, 2'd0, 5'd0, 1'b0, K_ERR, 7'd0, "resume_err");
        drive(1'b1, 1'b1, 3'd0, 12'd64, 9'h078, 2'd0, 5'd0, 1'b0, K_BE, 7'd0, "resume_be");
        idle("idle_end0");
        idle("idle_end1");

        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
